// File: rtl/complex_sinusoid_phase_estimator.sv
// complex_sinusoid_phase_estimator
//
// Receive-side companion of the complex sinusoid DDFS. Each accepted complex
// sample (I = real, Q = imag) is converted to its instantaneous phase by an
// iterative vectoring CORDIC, one micro-rotation per clock. Successive phases
// are differenced to give a frequency word in DDFS phase-increment units.
//
// Ports:
//   i_clk         clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_valid       input sample valid
//   o_ready       block can accept a sample this cycle (high only in IDLE)
//   i_real        signed I sample, DATA_WIDTH bits
//   i_imag        signed Q sample, DATA_WIDTH bits
//   o_valid       one-cycle pulse, result outputs updated
//   o_phase       unsigned phase, 0 = +I axis, 2^(PHASE_WIDTH-2) = +Q axis
//   o_freq        current phase minus previous phase, modulo 2^PHASE_WIDTH
//   o_freq_valid  o_freq is based on a valid previous phase
module complex_sinusoid_phase_estimator #(
   parameter int DATA_WIDTH  = 16,
   parameter int PHASE_WIDTH = 32,
   parameter int ITERATIONS  = 16
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_valid,
   output logic                   o_ready,
   input  logic [DATA_WIDTH-1:0]  i_real,
   input  logic [DATA_WIDTH-1:0]  i_imag,
   output logic                   o_valid,
   output logic [PHASE_WIDTH-1:0] o_phase,
   output logic [PHASE_WIDTH-1:0] o_freq,
   output logic                   o_freq_valid
);

   // Two integer headroom bits cover the CORDIC gain and negation of the most
   // negative input; the fractional guard bits stop the truncating shifts of
   // late iterations from eroding the phase accuracy.
   localparam int FRAC = 4;
   localparam int XW   = DATA_WIDTH + 2 + FRAC;
   localparam int IW   = $clog2(ITERATIONS);
   // The angle table is stored for a 32-bit full turn and rescaled here.
   localparam int UP   = (PHASE_WIDTH > 32) ? PHASE_WIDTH - 32 : 0;
   localparam int DN   = (PHASE_WIDTH < 32) ? 32 - PHASE_WIDTH : 0;

   typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;

   state_t                  state;
   state_t                  state_next;
   logic [IW-1:0]           iter;
   logic signed [XW-1:0]    x;
   logic signed [XW-1:0]    y;
   logic [PHASE_WIDTH-1:0]  z;
   logic                    zero_in;
   logic [PHASE_WIDTH-1:0]  prev_phase;
   logic                    have_prev;

   logic signed [XW-1:0]    x_in;
   logic signed [XW-1:0]    y_in;
   logic signed [XW-1:0]    x_sh;
   logic signed [XW-1:0]    y_sh;
   logic [PHASE_WIDTH-1:0]  atan_i;
   logic [PHASE_WIDTH-1:0]  phase_new;

   // atan(2^-i) / (2*pi) * 2^32, rounded, then rescaled to PHASE_WIDTH.
   function automatic logic [PHASE_WIDTH-1:0] atan_lut(input int idx);
      logic [63:0] base;
      logic [63:0] scaled;
      case (idx)
         0:       base = 64'd536870912;
         1:       base = 64'd316933406;
         2:       base = 64'd167458907;
         3:       base = 64'd85004756;
         4:       base = 64'd42667331;
         5:       base = 64'd21354465;
         6:       base = 64'd10679838;
         7:       base = 64'd5340245;
         8:       base = 64'd2670163;
         9:       base = 64'd1335087;
         10:      base = 64'd667544;
         11:      base = 64'd333772;
         12:      base = 64'd166886;
         13:      base = 64'd83443;
         14:      base = 64'd41722;
         15:      base = 64'd20861;
         16:      base = 64'd10430;
         17:      base = 64'd5215;
         18:      base = 64'd2608;
         19:      base = 64'd1304;
         20:      base = 64'd652;
         21:      base = 64'd326;
         22:      base = 64'd163;
         23:      base = 64'd81;
         default: base = 64'd0;
      endcase
      scaled = ((((base << 1) >> DN) + 64'd1) >> 1) << UP;
      return PHASE_WIDTH'(scaled);
   endfunction

   assign x_in      = {{2{i_real[DATA_WIDTH-1]}}, i_real, {FRAC{1'b0}}};
   assign y_in      = {{2{i_imag[DATA_WIDTH-1]}}, i_imag, {FRAC{1'b0}}};
   assign x_sh      = x >>> iter;
   assign y_sh      = y >>> iter;
   assign atan_i    = atan_lut(int'(iter));
   assign phase_new = zero_in ? '0 : z;
   assign o_ready   = (state == IDLE);

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state: accept in IDLE, rotate ITERATIONS cycles, report for one.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (i_valid) state_next = ROTATE;
         ROTATE:  if (iter == IW'(ITERATIONS - 1)) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath and registered outputs. The pre-rotation folds the left half
   // plane onto the right so the CORDIC only has to cover +/-90 degrees.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         iter         <= '0;
         x            <= '0;
         y            <= '0;
         z            <= '0;
         zero_in      <= 1'b0;
         prev_phase   <= '0;
         have_prev    <= 1'b0;
         o_valid      <= 1'b0;
         o_phase      <= '0;
         o_freq       <= '0;
         o_freq_valid <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (i_valid) begin
                  if (x_in[XW-1]) begin
                     x <= -x_in;
                     y <= -y_in;
                     z <= {1'b1, {(PHASE_WIDTH-1){1'b0}}};
                  end else begin
                     x <= x_in;
                     y <= y_in;
                     z <= '0;
                  end
                  iter    <= '0;
                  zero_in <= (i_real == '0) && (i_imag == '0);
               end
            end
            ROTATE: begin
               if (!y[XW-1]) begin
                  x <= x + y_sh;
                  y <= y - x_sh;
                  z <= z + atan_i;
               end else begin
                  x <= x - y_sh;
                  y <= y + x_sh;
                  z <= z - atan_i;
               end
               iter <= iter + 1'b1;
            end
            DONE: begin
               o_valid      <= 1'b1;
               o_phase      <= phase_new;
               o_freq       <= phase_new - prev_phase;
               o_freq_valid <= have_prev && !zero_in;
               prev_phase   <= phase_new;
               have_prev    <= !zero_in;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_complex_sinusoid_phase_estimator.sv
// tb_complex_sinusoid_phase_estimator
//
// Randomized and directed stimulus for complex_sinusoid_phase_estimator.
// Expected phases come from an ideal atan2 model; a monitor process pops the
// scoreboard on every o_valid pulse and compares within accuracy tolerances.
module tb_complex_sinusoid_phase_estimator;

   localparam int     DW        = 16;
   localparam int     PW        = 32;
   localparam int     ITER      = 16;
   localparam longint MASK      = 64'hFFFFFFFF;
   localparam longint TOL_PHASE = 65536;
   localparam longint TOL_FREQ  = 131072;
   localparam real    PI        = 3.14159265358979323846;

   typedef struct {
      longint phase;
      bit     freq_valid;
      longint freq;
      longint accept_cycle;
   } exp_t;

   logic          i_clk   = 1'b0;
   logic          i_rst_n = 1'b0;
   logic          i_valid = 1'b0;
   logic [DW-1:0] i_real  = '0;
   logic [DW-1:0] i_imag  = '0;
   logic          o_ready;
   logic          o_valid;
   logic [PW-1:0] o_phase;
   logic [PW-1:0] o_freq;
   logic          o_freq_valid;

   longint cycle_cnt    = 0;
   int     assert_count = 0;
   int     fail_count   = 0;
   int     valid_seen   = 0;
   exp_t   sb[$];
   longint model_prev   = 0;
   bit     model_have   = 1'b0;

   complex_sinusoid_phase_estimator #(
      .DATA_WIDTH (DW),
      .PHASE_WIDTH(PW),
      .ITERATIONS (ITER)
   ) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_real      (i_real),
      .i_imag      (i_imag),
      .o_valid     (o_valid),
      .o_phase     (o_phase),
      .o_freq      (o_freq),
      .o_freq_valid(o_freq_valid)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cycle_cnt <= cycle_cnt + 1;

   // Ideal phase of (re, im) in units of 2^-32 turn.
   function automatic longint ideal_phase(input int re, input int im);
      real    a;
      longint p;
      if (re == 0 && im == 0) return 0;
      a = $atan2(real'(im), real'(re));
      if (a < 0.0) a = a + 2.0 * PI;
      p = longint'(a / (2.0 * PI) * 4294967296.0);
      return p & MASK;
   endfunction

   // Compare modulo 2^32 within a tolerance; tol = 0 is an exact compare.
   task automatic checkOutput(input string name, input longint got,
                              input longint want, input longint tol);
      longint d;
      d = (got - want) & MASK;
      if (d >= 64'sh80000000) d = d - 64'sh100000000;
      if (d < 0) d = -d;
      assert_count++;
      if (d > tol) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (tol %0d) at cycle %0d",
                  name, got, want, tol, cycle_cnt);
      end
   endtask

   task automatic model_push(input int re, input int im, input longint acc);
      exp_t e;
      bit   zero;
      zero           = (re == 0 && im == 0);
      e.phase        = ideal_phase(re, im);
      e.freq_valid   = model_have && !zero;
      e.freq         = (e.phase - model_prev) & MASK;
      e.accept_cycle = acc;
      model_prev     = e.phase;
      model_have     = !zero;
      sb.push_back(e);
   endtask

   task automatic model_reset();
      sb.delete();
      model_prev = 0;
      model_have = 1'b0;
   endtask

   task automatic rand_sample(output int re, output int im);
      longint mag2;
      do begin
         re   = int'($urandom_range(65535)) - 32768;
         im   = int'($urandom_range(65535)) - 32768;
         mag2 = longint'(re) * re + longint'(im) * im;
      end while (mag2 < 64'd268435456);
   endtask

   // Present one sample and hold it until the block takes it.
   task automatic applyStimulus(input int re, input int im);
      int waited;
      bit done;
      waited  = 0;
      done    = 1'b0;
      i_valid = 1'b1;
      i_real  = re[DW-1:0];
      i_imag  = im[DW-1:0];
      while (!done) begin
         @(negedge i_clk);
         if (o_ready) begin
            model_push(re, im, cycle_cnt + 1);
            done = 1'b1;
         end else if (++waited > 100) begin
            checkOutput("ready_timeout", 0, 1, 0);
            done = 1'b1;
         end
         @(posedge i_clk);
         #1;
      end
      i_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge i_clk);
         n++;
      end
      checkOutput("drain_timeout", sb.size(), 0, 0);
      #1;
   endtask

   // i_valid held high with new data every cycle; only ready cycles consume.
   task automatic burst(input int n_acc);
      int     re, im, got, cycles;
      longint last_acc;
      got      = 0;
      cycles   = 0;
      last_acc = 0;
      rand_sample(re, im);
      i_valid = 1'b1;
      i_real  = re[DW-1:0];
      i_imag  = im[DW-1:0];
      while (got < n_acc && cycles < n_acc * (ITER + 2) + 50) begin
         @(negedge i_clk);
         if (o_ready) begin
            model_push(re, im, cycle_cnt + 1);
            if (got > 0) checkOutput("accept_gap", cycle_cnt + 1 - last_acc, ITER + 2, 0);
            last_acc = cycle_cnt + 1;
            got++;
         end
         @(posedge i_clk);
         #1;
         rand_sample(re, im);
         i_real = re[DW-1:0];
         i_imag = im[DW-1:0];
         cycles++;
      end
      i_valid = 1'b0;
      checkOutput("burst_accepts", got, n_acc, 0);
   endtask

   // Monitor: scoreboard pop and compare on every o_valid pulse.
   initial begin
      exp_t e;
      bit   prev_valid;
      prev_valid = 1'b0;
      forever begin
         @(negedge i_clk);
         if (!i_rst_n) begin
            prev_valid = 1'b0;
         end else begin
            if (o_valid) begin
               valid_seen++;
               checkOutput("valid_width", prev_valid, 0, 0);
               if (sb.size() == 0) begin
                  checkOutput("unexpected_valid", 1, 0, 0);
               end else begin
                  e = sb.pop_front();
                  checkOutput("phase", o_phase, e.phase, TOL_PHASE);
                  checkOutput("freq_valid", o_freq_valid, e.freq_valid, 0);
                  if (e.freq_valid) checkOutput("freq", o_freq, e.freq, TOL_FREQ);
                  checkOutput("latency", cycle_cnt - e.accept_cycle, ITER + 1, 0);
               end
            end
            prev_valid = o_valid;
         end
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int re, im, v0;

      // Reset state, with a sample presented that must be ignored.
      i_valid = 1'b1;
      i_real  = 16'd100;
      i_imag  = 16'd200;
      #12;
      checkOutput("rst_ready", o_ready, 1, 0);
      checkOutput("rst_valid", o_valid, 0, 0);
      checkOutput("rst_phase", o_phase, 0, 0);
      checkOutput("rst_freq", o_freq, 0, 0);
      checkOutput("rst_freq_valid", o_freq_valid, 0, 0);
      i_valid = 1'b0;
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;

      // Axis points and extremes, one at a time.
      applyStimulus(16384, 0);       wait_drain();
      applyStimulus(0, 16384);       wait_drain();
      applyStimulus(-16384, 0);      wait_drain();
      applyStimulus(0, -16384);      wait_drain();
      applyStimulus(16384, 16384);   wait_drain();
      applyStimulus(-32768, -32768); wait_drain();
      applyStimulus(32767, -32768);  wait_drain();

      // Frequency sequence from a clean history, including both wrap cases.
      i_rst_n = 1'b0;
      model_reset();
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      applyStimulus(16384, 0);
      applyStimulus(16384, 16384);
      applyStimulus(0, 16384);
      applyStimulus(0, -16384);
      applyStimulus(16384, 0);
      applyStimulus(0, 16384);
      applyStimulus(16384, 0);
      wait_drain();

      // Zero-magnitude sample clears the history.
      applyStimulus(0, 0);
      applyStimulus(16384, 0);
      applyStimulus(0, 16384);
      wait_drain();

      // Random samples, back to back.
      for (int k = 0; k < 20; k++) begin
         rand_sample(re, im);
         applyStimulus(re, im);
      end
      wait_drain();

      // Continuous i_valid with changing data.
      burst(5);
      wait_drain();

      // Reset while rotating at iter = 5.
      applyStimulus(16384, 16384);
      repeat (5) @(posedge i_clk);
      #1;
      i_rst_n = 1'b0;
      model_reset();
      #2;
      checkOutput("midrst_ready", o_ready, 1, 0);
      checkOutput("midrst_valid", o_valid, 0, 0);
      checkOutput("midrst_phase", o_phase, 0, 0);
      checkOutput("midrst_freq", o_freq, 0, 0);
      checkOutput("midrst_freq_valid", o_freq_valid, 0, 0);
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      v0 = valid_seen;
      repeat (ITER + 6) @(posedge i_clk);
      #1;
      checkOutput("aborted_no_valid", valid_seen, v0, 0);
      applyStimulus(0, 16384);
      applyStimulus(-16384, 0);
      wait_drain();

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
